rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
- Shares one byte-wide instruction ROM read port between two requesters: instruction fetch (if_*) and debug/loader read (dbg_*).
- Each granted request reads four consecutive bytes, one per clock, and assembles them big-endian (byte at addr -> bits 31:24) into a 32-bit word.
- The word is returned with a one-cycle ack pulse.
- Sits between the CPU fetch path / debug port and the ROM storage array.

Parameters:
- ROM_BYTES, 100, number of byte locations in the ROM (valid byte addresses 0..ROM_BYTES-1).

Ports:
- CLK  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; level, sampled only in IDLE.
- if_addr  input  32  fetch byte address; sampled at grant.
- if_ack  output  1  one-cycle pulse: if_data/if_err valid.
- if_data  output  32  assembled fetch word.
- if_err  output  1  fetch request rejected (misaligned or out of range).
- dbg_req  input  1  debug request; same rules as if_req.
- dbg_addr  input  32  debug byte address.
- dbg_ack  output  1  one-cycle pulse: dbg_data/dbg_err valid.
- dbg_data  output  32  assembled debug word.
- dbg_err  output  1  debug request rejected.
- rom_en  output  1  ROM read enable; high only in READ.
- rom_addr  output  32  ROM byte address.
- rom_byte  input  8  ROM read data; combinational from rom_addr while rom_en=1.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cnt=0, all outputs 0.
  - last_grant=DBG, so ifetch wins the first tie.
- States: IDLE, READ, DONE.
- IDLE arbitration, at the rising edge:
  - Only one req high: grant it.
  - Both high: grant the one not equal to last_grant (round-robin).
  - Grant latches base address, owner, and last_grant=owner.
- Validity check at grant:
  - Error if addr[1:0]!=0 or addr>ROM_BYTES-4.
  - Error -> DONE directly, word=0, err=1; rom_en never asserted.
  - Otherwise -> READ, cnt=0, word cleared.
- READ (exactly 4 cycles):
  - rom_en=1, rom_addr=base+cnt (registered).
  - Each edge: word <= {word[23:0], rom_byte}, cnt++.
  - After the cnt=3 capture -> DONE.
- DONE (1 cycle):
  - Owner's ack=1; owner's data=word, err=err flag.
  - The non-owner's outputs are unchanged.
  - Next state IDLE.
- Data/err outputs are registered and hold until that port's next ack.
- rom_en=0 outside READ; rom_addr holds its last value.
- Latency, counting the cycle req is seen in IDLE as cycle 0:
  - Valid read: rom_addr base..base+3 in cycles 1-4, ack in cycle 5.
  - Error: ack in cycle 1.
- Handshake:
  - addr must be stable in the IDLE cycle where the request is sampled.
  - Deasserting req after grant does not abort; ack is still issued.
  - A req still high in the IDLE cycle after ack is a new request, so back-to-back transfers are possible with one IDLE cycle between them.
  - The losing requester keeps waiting; no starvation under continuous contention.
- Reset mid-operation: immediate return to IDLE, rom_en=0, no ack, partial word discarded.
- Address arithmetic is unsigned 32-bit. base+cnt never wraps because valid bases are at most ROM_BYTES-4.

Test Plan:
- Reset, ROM bytes 0..3 = 20,01,00,08, if_req=1 with if_addr=0:
  - rom_addr 0,1,2,3 in cycles 1-4, rom_en high for exactly 4 cycles.
  - if_ack pulses in cycle 5 with if_data=0x20010008, if_err=0; dbg outputs stay 0.
- if_req and dbg_req raised together, both with addr 4, both held high:
  - Order: if_ack first, then dbg_ack 6 cycles later, then if_ack 6 cycles after that (round-robin).
  - Data = ROM bytes 4..7 each time.
- dbg_addr=96 (ROM_BYTES=100):
  - Normal read, rom_addr 96..99, dbg_err=0.
- dbg_addr=100:
  - dbg_ack in cycle 1, dbg_data=0, dbg_err=1, rom_en never high.
- if_addr=2 (misaligned):
  - if_ack in cycle 1, if_err=1, if_data=0, no ROM access.
- Reset asserted during READ with cnt=2, if_req held:
  - rom_en drops without waiting for the clock, no if_ack.
  - After reset release: full new 4-byte read from the same address, correct word.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one byte-wide ROM read port between the instruction
// fetch path and the debug/loader port. A granted request reads four consecutive
// bytes and returns one big-endian 32-bit word with a single-cycle ack.
module rom_fetch_arbiter #(
    parameter int unsigned ROM_BYTES = 100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_data_o,
    output logic        if_err_o,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_addr_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_data_o,
    output logic        dbg_err_o,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [7:0]  rom_byte_i
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_READ    = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam logic        OWN_IF    = 1'b0;
    localparam logic        OWN_DBG   = 1'b1;
    // Highest base address whose four bytes all lie inside the ROM.
    localparam logic [31:0] LAST_BASE = 32'(ROM_BYTES - 4);

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] word_q, word_d;
    logic        rom_en_q, rom_en_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] if_data_q, if_data_d;
    logic        if_err_q, if_err_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic [31:0] dbg_data_q, dbg_data_d;
    logic        dbg_err_q, dbg_err_d;

    logic        grant_any_c;
    logic        grant_dbg_c;
    logic [31:0] sel_addr_c;
    logic        addr_bad_c;
    logic [31:0] word_shift_c;
    logic        fin_c;
    logic        fin_owner_c;
    logic [31:0] fin_data_c;
    logic        fin_err_c;

    // Round-robin arbitration and address validity for the IDLE grant decision.
    always_comb begin
        grant_any_c  = if_req_i | dbg_req_i;
        grant_dbg_c  = dbg_req_i & (~if_req_i | (last_grant_q == OWN_IF));
        sel_addr_c   = grant_dbg_c ? dbg_addr_i : if_addr_i;
        addr_bad_c   = (sel_addr_c[1:0] != 2'b00) | (sel_addr_c > LAST_BASE);
        word_shift_c = {word_q[23:0], rom_byte_i};
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        if_ack_d     = 1'b0;
        if_data_d    = if_data_q;
        if_err_d     = if_err_q;
        dbg_ack_d    = 1'b0;
        dbg_data_d   = dbg_data_q;
        dbg_err_d    = dbg_err_q;
        fin_c        = 1'b0;
        fin_owner_c  = owner_q;
        fin_data_c   = 32'd0;
        fin_err_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_any_c) begin
                    owner_d      = grant_dbg_c;
                    last_grant_d = grant_dbg_c;
                    base_d       = sel_addr_c;
                    cnt_d        = 2'd0;
                    word_d       = 32'd0;
                    if (addr_bad_c) begin
                        // Rejected requests skip the ROM entirely.
                        state_d     = S_DONE;
                        fin_c       = 1'b1;
                        fin_owner_c = grant_dbg_c;
                        fin_data_c  = 32'd0;
                        fin_err_c   = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        rom_en_d   = 1'b1;
                        rom_addr_d = sel_addr_c;
                    end
                end
            end
            S_READ: begin
                word_d = word_shift_c;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d     = S_DONE;
                    fin_c       = 1'b1;
                    fin_owner_c = owner_q;
                    fin_data_c  = word_shift_c;
                    fin_err_c   = 1'b0;
                end else begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = base_q + 32'(cnt_q) + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result lands in the owner's registers so ack is visible in DONE.
        if (fin_c) begin
            if (fin_owner_c == OWN_DBG) begin
                dbg_ack_d  = 1'b1;
                dbg_data_d = fin_data_c;
                dbg_err_d  = fin_err_c;
            end else begin
                if_ack_d  = 1'b1;
                if_data_d = fin_data_c;
                if_err_d  = fin_err_c;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            base_q       <= 32'd0;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_DBG;
            word_q       <= 32'd0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= 32'd0;
            if_ack_q     <= 1'b0;
            if_data_q    <= 32'd0;
            if_err_q     <= 1'b0;
            dbg_ack_q    <= 1'b0;
            dbg_data_q   <= 32'd0;
            dbg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            if_ack_q     <= if_ack_d;
            if_data_q    <= if_data_d;
            if_err_q     <= if_err_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_data_q   <= dbg_data_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    assign if_ack_o   = if_ack_q;
    assign if_data_o  = if_data_q;
    assign if_err_o   = if_err_q;
    assign dbg_ack_o  = dbg_ack_q;
    assign dbg_data_o = dbg_data_q;
    assign dbg_err_o  = dbg_err_q;
    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Testbench for rom_fetch_arbiter: transaction-level reference model with a
// byte-array ROM, directed scenarios and randomized request mixes.
module tb_rom_fetch_arbiter;

    localparam int ROM_BYTES = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_data;
    logic        if_err;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic        dbg_err;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [7:0]  rom_byte;

    logic [7:0]  rom_mem [0:ROM_BYTES-1];

    int tests_run = 0;
    int failures  = 0;

    // Model state: who won the last tie, and each port's held result.
    bit          model_last_dbg;
    logic [31:0] exp_if_data, exp_dbg_data;
    logic        exp_if_err, exp_dbg_err;

    rom_fetch_arbiter #(.ROM_BYTES(ROM_BYTES)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_ack_o(if_ack), .if_data_o(if_data), .if_err_o(if_err),
        .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
        .dbg_ack_o(dbg_ack), .dbg_data_o(dbg_data), .dbg_err_o(dbg_err),
        .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_byte_i(rom_byte)
    );

    always #5 clk = ~clk;

    // Combinational ROM storage array.
    always_comb begin
        rom_byte = 8'h00;
        if (rom_en && rom_addr < 32'(ROM_BYTES))
            rom_byte = rom_mem[int'(rom_addr)];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_last_dbg = 1'b1;
        exp_if_data    = 32'd0;
        exp_dbg_data   = 32'd0;
        exp_if_err     = 1'b0;
        exp_dbg_err    = 1'b0;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        if_req  = 1'b0;
        dbg_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rom_word(input int a);
        return {rom_mem[a], rom_mem[a+1], rom_mem[a+2], rom_mem[a+3]};
    endfunction

    // One arbitrated transaction, checked cycle by cycle from the grant on.
    task automatic run_txn(input bit rq_if, input bit rq_dbg,
                           input logic [31:0] a_if, input logic [31:0] a_dbg);
        bit          own_dbg;
        bit          ok;
        logic [31:0] a;
        logic [31:0] w;
        int          ack_c;
        bit          exp_en;
        own_dbg = rq_dbg && (!rq_if || !model_last_dbg);
        model_last_dbg = own_dbg;
        a  = own_dbg ? a_dbg : a_if;
        ok = (a % 32'd4 == 32'd0) && (a <= 32'(ROM_BYTES - 4));
        w  = ok ? rom_word(int'(a)) : 32'd0;
        ack_c = ok ? 5 : 1;
        if_req   = rq_if;
        if_addr  = a_if;
        dbg_req  = rq_dbg;
        dbg_addr = a_dbg;
        for (int c = 1; c <= ack_c; c++) begin
            tick();
            if (c == 1) begin
                if_req  = 1'b0;
                dbg_req = 1'b0;
            end
            exp_en = ok && (c <= 4);
            tests_run++;
            if (rom_en !== exp_en) begin
                failures++;
                $display("FAIL rom_en a=%0d c=%0d: got %b want %b", a, c, rom_en, exp_en);
            end
            if (exp_en) begin
                tests_run++;
                if (rom_addr !== a + 32'(c - 1)) begin
                    failures++;
                    $display("FAIL rom_addr a=%0d c=%0d: got %0d want %0d", a, c, rom_addr, a + 32'(c - 1));
                end
            end
            tests_run++;
            if (if_ack !== (c == ack_c && !own_dbg) || dbg_ack !== (c == ack_c && own_dbg)) begin
                failures++;
                $display("FAIL ack a=%0d c=%0d: got if=%b dbg=%b want if=%b dbg=%b", a, c,
                         if_ack, dbg_ack, (c == ack_c && !own_dbg), (c == ack_c && own_dbg));
            end
        end
        if (own_dbg) begin
            exp_dbg_data = w;
            exp_dbg_err  = !ok;
        end else begin
            exp_if_data = w;
            exp_if_err  = !ok;
        end
        tests_run++;
        if (if_data !== exp_if_data || if_err !== exp_if_err) begin
            failures++;
            $display("FAIL if_result a=%0d: got %h/%b want %h/%b", a, if_data, if_err, exp_if_data, exp_if_err);
        end
        tests_run++;
        if (dbg_data !== exp_dbg_data || dbg_err !== exp_dbg_err) begin
            failures++;
            $display("FAIL dbg_result a=%0d: got %h/%b want %h/%b", a, dbg_data, dbg_err, exp_dbg_data, exp_dbg_err);
        end
        tick();
        tests_run++;
        if (rom_en !== 1'b0 || if_ack !== 1'b0 || dbg_ack !== 1'b0) begin
            failures++;
            $display("FAIL idle_after a=%0d: got en=%b ia=%b da=%b want 0 0 0", a, rom_en, if_ack, dbg_ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; if_addr = 32'd0; dbg_addr = 32'd0;
        tick();
        tests_run++;
        if ({if_ack, if_data, if_err, dbg_ack, dbg_data, dbg_err, rom_en, rom_addr} !== 101'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0",
                     {if_ack, if_data, if_err, dbg_ack, dbg_data, dbg_err, rom_en, rom_addr});
        end
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_fetch();
        rom_mem[0] = 8'h20; rom_mem[1] = 8'h01; rom_mem[2] = 8'h00; rom_mem[3] = 8'h08;
        run_txn(1'b1, 1'b0, 32'd0, 32'd0);
        tests_run++;
        if (if_data !== 32'h2001_0008) begin
            failures++;
            $display("FAIL basic_word: got %h want 20010008", if_data);
        end
    endtask

    // Both requesters held high on addr 4: expect IF, DBG, IF six cycles apart.
    task automatic test_contention();
        logic [31:0] w;
        bit          e_if, e_dbg, e_en;
        apply_reset();
        w = rom_word(4);
        if_req = 1'b1; dbg_req = 1'b1; if_addr = 32'd4; dbg_addr = 32'd4;
        for (int c = 1; c <= 17; c++) begin
            tick();
            e_if  = (c == 5) || (c == 17);
            e_dbg = (c == 11);
            e_en  = ((c % 6) >= 1) && ((c % 6) <= 4);
            tests_run++;
            if (if_ack !== e_if || dbg_ack !== e_dbg || rom_en !== e_en) begin
                failures++;
                $display("FAIL contention c=%0d: got ia=%b da=%b en=%b want %b %b %b",
                         c, if_ack, dbg_ack, rom_en, e_if, e_dbg, e_en);
            end
            if (e_if || e_dbg) begin
                tests_run++;
                if ((e_if ? if_data : dbg_data) !== w || (e_if ? if_err : dbg_err) !== 1'b0) begin
                    failures++;
                    $display("FAIL contention_data c=%0d: got %h want %h", c, e_if ? if_data : dbg_data, w);
                end
            end
        end
        if_req = 1'b0; dbg_req = 1'b0;
        tick();
        model_last_dbg = 1'b0;
        exp_if_data = w; exp_dbg_data = w;
    endtask

    task automatic test_dbg_boundary();
        run_txn(1'b0, 1'b1, 32'd0, 32'd96);
        run_txn(1'b0, 1'b1, 32'd0, 32'd100);
    endtask

    task automatic test_misaligned();
        run_txn(1'b1, 1'b0, 32'd2, 32'd0);
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1; if_addr = 32'd40;
        tick(); tick(); tick();
        tests_run++;
        if (rom_addr !== 32'd42 || rom_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_read_pos: got %0d/%b want 42/1", rom_addr, rom_en);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (rom_en !== 1'b0 || if_ack !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got en=%b ack=%b want 0 0", rom_en, if_ack);
        end
        tick(); tick();
        rst = 1'b0;
        model_reset();
        tests_run++;
        if (if_ack !== 1'b0 || if_data !== 32'd0) begin
            failures++;
            $display("FAIL post_reset: got ack=%b data=%h want 0 0", if_ack, if_data);
        end
        run_txn(1'b1, 1'b0, 32'd40, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0, 1: return 32'($urandom_range(0, 24) * 4);
            2:    return 32'($urandom_range(0, 24) * 4 + $urandom_range(1, 3));
            3:    return 32'(100 + $urandom_range(0, 40) * 4);
            default: return ($urandom_range(0, 1) == 0) ? 32'd96 : 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic test_random();
        int k;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(1, 3);
            run_txn(k[0], k[1], rand_addr(), rand_addr());
        end
    endtask

    initial begin
        for (int i = 0; i < ROM_BYTES; i++) rom_mem[i] = 8'($urandom);
        test_reset();
        test_basic_fetch();
        test_contention();
        test_dbg_boundary();
        test_misaligned();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
